// File: rtl/serial_addsub_ctrl.sv
// Nibble-serial adder/subtractor: one 4-bit slice per cycle, LS nibble first.
// Status flags are captured on the edge that writes the last slice.
module serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry,
  output logic                   zero,
  output logic                   overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  result_next;
  logic [IW-1:0] idx;
  logic          cin;
  logic          sub_r;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    slice;
  logic          last;
  logic          load;

  // Slice datapath; result_next is the result with the current nibble merged.
  always_comb begin
    a_nib       = 4'(a_r >> {idx, 2'b00});
    b_nib       = 4'(b_r >> {idx, 2'b00});
    slice       = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, cin};
    result_next = result;
    result_next[{idx, 2'b00} +: 4] = slice[3:0];
    last        = (idx == IW'(NIBBLES - 1));
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      idx      <= '0;
      cin      <= 1'b0;
      sub_r    <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        a_r   <= a;
        b_r   <= sub ? ~b : b;
        cin   <= sub;
        sub_r <= sub;
        idx   <= '0;
      end else if (state == RUN) begin
        result <= result_next;
        cin    <= slice[4];
        idx    <= last ? '0 : idx + 1'b1;
        if (last) begin
          carry    <= slice[4] ^ sub_r;
          zero     <= ~|result_next;
          overflow <= (a_r[W-1] == b_r[W-1]) &&
                      (result_next[W-1] != a_r[W-1]);
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized scoreboard bench for serial_addsub_ctrl.
// Expected results come from plain integer add/subtract of the operands.
module tb_serial_addsub_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         overflow;

  serial_addsub_ctrl #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         cy;
    logic         zr;
    logic         ov;
    int           due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rem = 0;
  bit   acc = 0;
  bit   done_exp = 0;
  int   prev_done = -100;
  int   done_gap = 0;
  logic [W-1:0] h_res = '0;
  logic h_cy = 0;
  logic h_zr = 0;
  logic h_ov = 0;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input int due);
    exp_t e;
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint full;
    longint sr;
    full   = s ? (ux - uy) : (ux + uy);
    sr     = s ? (sx - sy) : (sx + sy);
    e.res  = W'(full);
    e.cy   = s ? (ux < uy) : (full >= (64'sd1 <<< W));
    e.zr   = (e.res == '0);
    e.ov   = (sr > ((64'sd1 <<< (W - 1)) - 1)) || (sr < -(64'sd1 <<< (W - 1)));
    e.due  = due;
    return e;
  endfunction

  // Reference timing: an accepted op keeps the unit busy for N cycles,
  // then a one-cycle done in which a new start may be taken.
  always @(posedge clk) begin
    cyc++;
    done_exp = 0;
    if (rst) begin
      rem   = 0;
      acc   = 0;
      q.delete();
      h_res = '0;
      h_cy  = 0;
      h_zr  = 0;
      h_ov  = 0;
    end else begin
      acc = start && (rem == 0);
      if (rem > 0) begin
        rem--;
        if (rem == 0) done_exp = 1;
      end
      if (acc) begin
        rem = N;
        q.push_back(model(a, b, sub, cyc + N));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", W'(busy), W'(rem > 0));
      chk("done", W'(done), W'(done_exp));
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", W'(1), W'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", W'(cyc), W'(e.due));
          chk("result", result, e.res);
          chk("carry", W'(carry), W'(e.cy));
          chk("zero", W'(zero), W'(e.zr));
          chk("overflow", W'(overflow), W'(e.ov));
          h_res = e.res;
          h_cy  = e.cy;
          h_zr  = e.zr;
          h_ov  = e.ov;
          done_gap  = cyc - prev_done;
          prev_done = cyc;
        end
      end else begin
        chk("carry_hold", W'(carry), W'(h_cy));
        chk("zero_hold", W'(zero), W'(h_zr));
        chk("ovf_hold", W'(overflow), W'(h_ov));
        if (rem == 0) chk("result_hold", result, h_res);
      end
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic isub);
    @(negedge clk);
    a     = ia;
    b     = ib;
    sub   = isub;
    start = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", W'(0), W'(1));
  endtask

  task automatic drop_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rem != 0 || q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", W'(0), W'(1));
    @(negedge clk);
  endtask

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                    input logic isub);
    issue(ia, ib, isub);
    drop_start();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_result", result, '0);
    chk("rst_flags", W'({carry, zero, overflow}), W'(0));
    rst = 1'b0;

    op(16'h1234, 16'h4321, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0);
    op(16'h0005, 16'h0007, 1'b1);
    op(16'h8000, 16'h0001, 1'b1);
    op(16'h0000, 16'h0000, 1'b1);

    // Start held during RUN with changing operands is ignored.
    issue(16'h0102, 16'h0304, 1'b0);
    repeat (3) begin
      @(negedge clk);
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
    end
    drop_start();
    wait_idle();

    // Back-to-back: second start is taken in the done cycle.
    issue(16'hAAAA, 16'h1111, 1'b1);
    issue(16'h0F0F, 16'hF0F1, 1'b0);
    drop_start();
    wait_idle();
    chk("b2b_gap", W'(done_gap), W'(N + 1));

    // Reset two cycles into RUN aborts without a done pulse.
    issue(16'h1357, 16'h2468, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_result", result, '0);
    chk("abort_flags", W'({carry, zero, overflow}), W'(0));
    rst = 1'b0;
    op(16'h4000, 16'h4000, 1'b0);

    for (int i = 0; i < 150; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        @(negedge clk);
        a = W'($urandom);
        b = W'($urandom);
      end
      if ($urandom_range(0, 3) != 0) begin
        drop_start();
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    drop_start();
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request a new operation; accepted only when busy=0.
REQ-005 sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 a  input  W  operand A; sampled with start.
REQ-007 b  input  W  operand B; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; result flags valid from this cycle.
REQ-010 result  output  W  sum/difference.
REQ-011 carry  output  1  carry (add) / borrow (sub).
REQ-012 zero  output  1  result equals 0.
REQ-013 overflow  output  1  two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: start=1 -> latch A, B_eff (= ~b if sub else b), cin = sub, sub flag, nibble index = 0; go to RUN.
REQ-016 RUN: each cycle, one 4-bit slice SHALL compute {cout, s} = A[idx] + B_eff[idx] + cin (5-bit result, zero-extended inputs).
REQ-017 RUN: s SHALL be written to result nibble idx; cin <= cout; idx <= idx+1; LS nibble first.
REQ-018 RUN with idx = NIBBLES-1 SHALL transition to DONE after that slice is written.
REQ-019 DONE: done=1 for exactly one cycle; next state IDLE, or RUN if start=1 in that cycle (back-to-back accepted, new operands latched).
REQ-020 busy SHALL be 1 in RUN and DONE-with-no-new-start excluded, i.e. busy=1 exactly in RUN.
REQ-021 Latency: start sampled at edge T -> done=1 in the cycle after edge T+NIBBLES (NIBBLES+1 edges total).
REQ-022 carry SHALL equal final cout XOR sub (borrow convention on subtract).
REQ-023 overflow SHALL equal (A[W-1] == B_eff[W-1]) AND (result[W-1] != A[W-1]).
REQ-024 zero SHALL equal NOR of all result bits.
REQ-025 carry, zero, overflow SHALL be updated on the edge entering DONE and held until the next edge entering DONE or reset.
REQ-026 result SHALL hold its final value from DONE until the first RUN slice write of the next operation; during RUN, unwritten nibbles hold old contents.
REQ-027 start while busy=1 SHALL be ignored; a, b, sub changes during RUN SHALL NOT affect the operation in flight.
REQ-028 Width arithmetic: all sums modulo 2^W; no saturation.

Reset
REQ-029 rst=1 SHALL force state IDLE, idx=0, cin=0, busy=0, done=0, result=0, carry=0, zero=0, overflow=0 at the next edge.
REQ-030 rst has priority over start and over any in-flight RUN; an aborted operation SHALL produce no done pulse.
REQ-031 After rst deasserts, start SHALL be accepted on the first edge with rst=0.

Verification (NIBBLES=4)
REQ-032 Add 0x1234+0x4321 -> result 0x5555, carry 0, zero 0, overflow 0; done exactly 5 cycles after start edge.
REQ-033 Add 0xFFFF+0x0001 -> result 0x0000, carry 1, zero 1, overflow 0; add 0x7FFF+0x0001 -> 0x8000, carry 0, overflow 1.
REQ-034 Sub 0x0005-0x0007 -> result 0xFFFE, carry(borrow) 1, zero 0, overflow 0; sub 0x8000-0x0001 -> 0x7FFF, carry 0, overflow 1.
REQ-035 Start held high for 3 cycles during RUN with changing a/b -> single operation on first-sampled operands; second start in DONE cycle -> back-to-back result, done pulses 5 cycles apart.
REQ-036 rst asserted 2 cycles into RUN -> next cycle busy 0, all outputs 0, no done pulse; new start afterward completes normally.
